// File: rtl/store_drain_pkg.sv
// Shared types and default widths for the store drain queue.
// Entry layout here fixes the ADDR_W/DATA_W used by store_drain.
package store_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_drain_if.sv
// Memory write request/ack handshake between the drain queue and memory.
// master drives the request, slave returns the ack.
interface store_drain_if
  import store_pkg::*;
#(
  parameter int ADDR_W = store_pkg::ADDR_W,
  parameter int DATA_W = store_pkg::DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/store_drain_fwd_cam.sv
// Load-forwarding lookup over the queued stores.
// Scans oldest to youngest so the youngest match wins.
module store_fwd_cam
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]    valid,
  input  logic [PW-1:0]       head,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                hit,
  output logic [DATA_W-1:0]   data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] &&
          (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_drain.sv
// Store-buffer drain queue: FIFO of stores written to memory one at a time.
// Define STORE_DRAIN_FWD_EN to enable load forwarding (ld_hit/ld_data).
module store_drain
  import store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = store_pkg::ADDR_W,
  parameter int DATA_W = store_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic              overflow,
  store_drain_if.master     mem,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  state_t            state;
  logic              ovf_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  entry_t            ent_q [DEPTH];

  logic push;
  logic pop;

  assign pop  = (state == REQ) && mem.mem_ack;
  assign full = (count == (PW+1)'(DEPTH));
  assign push = in_wen && (!full || pop);

  assign overflow      = ovf_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // Storage is not reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[tail] <= '{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      state   <= IDLE;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count
             + {{PW{1'b0}}, push}
             - {{PW{1'b0}}, pop};
      if (in_wen && full && !pop) ovf_q <= 1'b1;
      unique case (1'b1)
        (state == IDLE) && (count != '0): begin
          state   <= REQ;
          req_q   <= 1'b1;
          addr_q  <= ent_q[head].addr;
          wdata_q <= ent_q[head].data;
        end
        (state == REQ) && mem.mem_ack: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef STORE_DRAIN_FWD_EN
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;

  // Slot j is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off      = PW'(j) - head;
      valid[j] = ({1'b0, off} < count);
    end
  end

  store_fwd_cam #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_cam (
    .entries (ent_q),
    .valid   (valid),
    .head    (head),
    .ld_addr (ld_addr),
    .hit     (ld_hit),
    .data    (ld_data)
  );
`else
  logic unused_ld;

  assign unused_ld = ^ld_addr;
  assign ld_hit    = 1'b0;
  assign ld_data   = '0;
`endif

endmodule

// File: tb/tb_store_drain.sv
// Directed bench for store_drain with a scoreboard of expected requests.
// Forwarding expectations follow STORE_DRAIN_FWD_EN.
module tb_store_drain;
  import store_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 8;

`ifdef STORE_DRAIN_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_wen = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] ld_addr = '0;
  logic          full;
  logic          overflow;
  logic          ld_hit;
  logic [DW-1:0] ld_data;

  int     n_chk = 0;
  int     n_fail = 0;
  entry_t sb [$];
  entry_t e;

  store_drain_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  store_drain #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_wen   (in_wen),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .full     (full),
    .overflow (overflow),
    .mem      (mif),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input bit keep);
    in_wen  = 1'b1;
    in_addr = a;
    in_data = d;
    if (keep) sb.push_back('{addr: a, data: d});
  endtask

  // Wait (bounded) for a request, check it against the oldest
  // expected store, then ack it on the next edge.
  task automatic drain_one(input string tag);
    entry_t x;
    for (int i = 0; i < 8 && mif.mem_req !== 1'b1; i++)
      step();
    chk({tag, "_req"}, 32'(mif.mem_req), 32'd1);
    x = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_addr"}, 32'(mif.mem_addr), 32'(x.addr));
    chk({tag, "_data"}, 32'(mif.mem_wdata), 32'(x.data));
    mif.mem_ack = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    mif.mem_ack = 1'b0;
    step();
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_addr", 32'(mif.mem_addr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_hit", 32'(ld_hit), 0);
    chk("rst_cnt", 32'(dut.count), 0);
    rst_n = 1'b1;
    step();

    // single store, ack tied high
    mif.mem_ack = 1'b1;
    drive(16'h1234, 8'hAB, 1);
    step();
    in_wen = 1'b0;
    chk("t1_noreq", 32'(mif.mem_req), 0);
    step();
    chk("t1_req1", 32'(mif.mem_req), 1);
    drain_one("t1");
    chk("t1_cnt", 32'(dut.count), 0);
    chk("t1_idle", 32'(mif.mem_req), 0);

    // youngest match forwards
    mif.mem_ack = 1'b0;
    ld_addr = 16'h0010;
    drive(16'h0010, 8'h11, 1);
    step();
    drive(16'h0010, 8'h22, 1);
    step();
    in_wen = 1'b0;
    chk("t2_cnt", 32'(dut.count), 2);
    chk("t2_hit", 32'(ld_hit), 32'(FWD));
    chk("t2_dat", 32'(ld_data), FWD ? 32'h22 : 32'h0);
    drain_one("t2a");
    chk("t2_hit1", 32'(ld_hit), 32'(FWD));
    chk("t2_dat1", 32'(ld_data), FWD ? 32'h22 : 32'h0);
    drain_one("t2b");
    chk("t2_hit0", 32'(ld_hit), 0);
    chk("t2_dat0", 32'(ld_data), 0);

    // full queue, push and pop on the same edge
    mif.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(16'h0400 + 16'(k), 8'h40 + 8'(k), 1);
      step();
    end
    in_wen = 1'b0;
    chk("t3_full", 32'(full), 1);
    chk("t3_cnt4", 32'(dut.count), 4);
    chk("t3_ovf0", 32'(overflow), 0);
    e = sb.pop_front();
    chk("t3_haddr", 32'(mif.mem_addr), 32'(e.addr));
    drive(16'h0404, 8'h44, 1);
    mif.mem_ack = 1'b1;
    step();
    in_wen = 1'b0;
    mif.mem_ack = 1'b0;
    chk("t3_cnt", 32'(dut.count), 4);
    chk("t3_full2", 32'(full), 1);
    chk("t3_ovf", 32'(overflow), 0);
    for (int k = 0; k < 4; k++) drain_one("t3d");
    chk("t3_empty", 32'(dut.count), 0);

    // overflow: five pushes with no ack
    mif.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(16'h0100 + 16'(k), 8'h30 + 8'(k), k < 4);
      step();
      if (k == 3) begin
        chk("t4_full", 32'(full), 1);
        chk("t4_ovf0", 32'(overflow), 0);
      end
    end
    in_wen = 1'b0;
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_cnt", 32'(dut.count), 4);
    chk("t4_addr", 32'(mif.mem_addr), 32'h0100);
    step();
    step();
    step();
    chk("t4_hreq", 32'(mif.mem_req), 1);
    chk("t4_haddr", 32'(mif.mem_addr), 32'h0100);
    chk("t4_hdata", 32'(mif.mem_wdata), 32'h30);
    for (int k = 0; k < 4; k++) drain_one("t4d");
    chk("t4_sticky", 32'(overflow), 1);

    // pointer wrap, FIFO order
    for (int k = 0; k < 10; k++) begin
      drive(16'h0200 + 16'(k * 3), 8'h60 + 8'(k), 1);
      step();
      in_wen = 1'b0;
      drain_one("t5");
    end
    chk("t5_cnt", 32'(dut.count), 0);

    // reset while a request is in flight
    mif.mem_ack = 1'b0;
    ld_addr = 16'h0300;
    drive(16'h0300, 8'h55, 0);
    step();
    in_wen = 1'b0;
    step();
    chk("t6_req", 32'(mif.mem_req), 1);
    chk("t6_hit", 32'(ld_hit), 32'(FWD));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rreq", 32'(mif.mem_req), 0);
    chk("t6_rcnt", 32'(dut.count), 0);
    chk("t6_raddr", 32'(mif.mem_addr), 0);
    chk("t6_rovf", 32'(overflow), 0);
    chk("t6_rhit", 32'(ld_hit), 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t6_hit0", 32'(ld_hit), 0);
    chk("t6_req0", 32'(mif.mem_req), 0);
    chk("t6_cnt0", 32'(dut.count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
